// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, byte-enable and error constants.
package mem_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0]  BE_WORD  = 4'hF;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Single-lane enable for a byte store at the given word offset.
    function automatic logic [3:0] byte_be(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register: loads on 'load', clears asynchronously on rst low.
module mem_stage_memwb_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over req/ack with sb merge, stall control, MEM/WB register.
// Optional access timeout with sticky mem_err is enabled by defining DMEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [31:0]   IRin,
    input  logic [31:0]   PCin,
    input  logic          mtrin,
    input  logic          rdin,
    input  logic          jalin,
    input  logic          sravin,
    input  logic          sbin,
    input  logic          rwin,
    input  logic          mwin,
    input  logic [31:0]   r1in,
    input  logic [31:0]   r2in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic          mem_stall,
    output logic [31:0]   IRout,
    output logic [31:0]   PCout,
    output logic          mtrout,
    output logic          rdout,
    output logic          jalout,
    output logic          sravout,
    output logic          rwout,
    output logic [31:0]   aluout,
    output logic [31:0]   memout,
    output logic          mem_err
);

    localparam int unsigned WB_W = 32 + 32 + 5 + 32 + 32;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_op, is_load, is_sb, timeout;

    assign mem_op  = mtrin | mwin;
    // A combined load/store request is treated as a store, so it never returns data.
    assign is_load = mtrin & ~mwin;
    assign is_sb   = mwin & sbin;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign cnt_d   = (state_q == ST_WAIT) ? cnt_q + CW'(1) : '0;
    assign timeout = (state_q == ST_WAIT) && !dmem_ack && (cnt_q == CW'(TIMEOUT - 1));
    assign err_d   = err_q | timeout;
    assign mem_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d = ST_WAIT;
                    addr_d  = {r1in[AW-1:2], 2'b00};
                    we_d    = mwin;
                    be_d    = is_sb ? byte_be(r1in[1:0]) : BE_WORD;
                    wdata_d = !mwin ? 32'h0 : (is_sb ? {4{r2in[7:0]}} : r2in);
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    rdata_d = is_load ? dmem_rdata : 32'h0;
                end else if (timeout) begin
                    state_d = ST_DONE;
                    rdata_d = ERR_DATA;
                end
            end
            ST_DONE: begin
                if (en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign dmem_req   = (state_q == ST_WAIT);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign mem_stall  = mem_op & (state_q != ST_DONE);

    logic [WB_W-1:0] wb_d, wb_q;
    logic [31:0]     mem_data;

    // MEM/WB only loads in DONE for memory ops, so rdata_q is the latched result there.
    assign mem_data = mem_op ? rdata_q : 32'h0;
    assign wb_d     = {IRin, PCin, mtrin, rdin, jalin, sravin, rwin, r1in, mem_data};

    mem_stage_memwb_reg #(
        .W(WB_W)
    ) u_memwb_reg (
        .clk (clk),
        .rst (rst),
        .load(en & ~mem_stall),
        .d   (wb_d),
        .q   (wb_q)
    );

    assign {IRout, PCout, mtrout, rdout, jalout, sravout, rwout, aluout, memout} = wb_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register.
- Consumes EX/MEM outputs (IR, PC, control flags, ALU result r1, store data r2) and performs the data-memory access over a req/ack handshake, with byte-store merge for sb.
- Holds the pipeline via mem_stall while an access is outstanding, then loads the MEM/WB register feeding write-back.

Parameters:
- AW, 32, data-memory address width.
- TIMEOUT, 255, max cycles waiting for dmem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance enable from hazard unit; MEM/WB loads only when en=1 and mem_stall=0.
- IRin, PCin  in  32 each  instruction and PC from EX/MEM.
- mtrin, rdin, jalin, sravin, sbin, rwin, mwin  in  1 each  EX/MEM control flags. mtr = load, mw = store, sb = byte store; the others pass through.
- r1in  in  32  ALU result / memory address.
- r2in  in  32  store data.
- dmem_req  out  1  access request, held until ack.
- dmem_we  out  1  write strobe.
- dmem_addr  out  AW  word-aligned address, low 2 bits forced to 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  one-cycle completion pulse.
- mem_stall  out  1  drives ~en of EX/MEM and upstream registers.
- IRout, PCout  out  32 each  MEM/WB copies.
- mtrout, rdout, jalout, sravout, rwout  out  1 each  MEM/WB flag copies.
- aluout  out  32  registered r1in.
- memout  out  32  registered load data.
- mem_err  out  1  sticky timeout error (optional feature).

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all registered outputs and dmem_* outputs clear to 0; pending access is dropped. No access is issued until the first clock after reset release.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if mtrin|mwin, go to WAIT. Otherwise stay in IDLE.
  - WAIT: dmem_req=1; addr, we, be and wdata are registered on entry and held stable. On dmem_ack, capture dmem_rdata (loads only) and go to DONE.
  - DONE: if en=1, go to IDLE. Otherwise hold DONE.
- mem_stall = (mtrin|mwin) & (state!=DONE), combinational.
- Non-memory instruction: zero stall; MEM/WB loads at the next edge when en=1.
- Memory instruction: minimum 2 stall cycles; with ack in the first WAIT cycle, the stage is occupied 3 cycles.
- Store word (mw=1, sb=0): be=4'hF, wdata=r2in.
- Store byte (mw=1, sb=1): be = 1<<r1in[1:0], wdata = {4{r2in[7:0]}}.
- Load (mtr=1): we=0, be=4'hF; memout = dmem_rdata as latched at ack.
- mtr=1 and mw=1 together: treated as store; memout=0.
- dmem_ack outside WAIT is ignored.
- MEM/WB register: on clk with en=1 and mem_stall=0, loads all pass-through fields, aluout and memout. For a non-load, memout loads 0. Otherwise holds.
- sbin is not forwarded; write-back does not need it.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter runs in WAIT. When it reaches TIMEOUT with no ack:
  - go to DONE;
  - memout = 32'hDEAD_BEEF;
  - mem_err set, sticky until reset.
- Undefined: WAIT has no bound; mem_err is tied to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), BE_WORD=4'hF, ERR_DATA=32'hDEAD_BEEF.
- Sub-module memwb_reg: enable-gated, async-active-low-cleared MEM/WB register, reusable by the write-back stage bench.

Test Plan:
- Reset mid-WAIT: assert rst=0 while dmem_req=1 -> same cycle dmem_req=0, state IDLE, all outputs 0.
- ALU op, r1in=32'h0000_0042, rwin=1, en=1 -> mem_stall=0; next edge aluout=32'h42, rwout=1, memout=0.
- sb with r1in=32'h1003, r2in=32'h1234_56AB, ack after 2 WAIT cycles -> dmem_addr=32'h1000, be=4'b1000, wdata=32'hABAB_ABAB; mem_stall high for 3 cycles.
- lw with r1in=32'h2000, dmem_rdata=32'hCAFE_F00D, ack in first WAIT cycle -> memout=32'hCAFE_F00D, mtrout=1, total 2 stall cycles.
- Back-to-back lw then sw -> second access starts in IDLE the cycle after DONE; no lost or duplicated dmem_req.
- DMEM_TIMEOUT_EN defined, TIMEOUT=4, ack never given -> after 4 WAIT cycles memout=32'hDEAD_BEEF and mem_err=1 held until reset.
